vend_dispense_sequencer: RTL
============================

# vend_dispense_sequencer

Sequencer that owns the vending machine's physical actuators: four item motors and two coin hoppers (5 and 10 units). It accepts one vend transaction at a time (slot, quantity, change owed) over a valid/ready handshake, checks the slot's stock counter, and fires the actuators strictly one at a time, waiting for a mechanism acknowledge after each. It sits between the purchase/pricing FSM upstream and the mechanism drivers downstream, and it is the single owner of per-slot stock counts.

## Interface
- PULSE_CYCLES, 4: width of each actuator fire pulse, in clk cycles (≥1).
- TIMEOUT_CYCLES, 1000: cycles allowed after a pulse ends before a missing acknowledge is declared a fault.
- STOCK_W, 6: per-slot stock counter width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  transaction offered.
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready.
- req_item  in  2  slot index 0..3.
- req_qty  in  2  items to vend; legal values 1, 2.
- req_change  in  3  change owed, in 5-unit multiples (0..7 = 0..35).
- load_en  in  1  restock strobe.
- load_item  in  2  slot to restock.
- load_count  in  STOCK_W  new absolute stock value.
- mech_done  in  1  one-cycle acknowledge from the mechanism currently fired.
- motor_fire  out  4  one-hot item motor drive.
- coin5_fire  out  1  5-unit hopper drive.
- coin10_fire  out  1  10-unit hopper drive.
- done_valid  out  1  one-cycle completion strobe.
- done_status  out  2  0 OK, 1 NO_STOCK, 2 BAD_QTY, 3 FAULT; valid with done_valid.
- stock  out  4*STOCK_W  packed stock counts, slot 0 in LSBs.

## Operation
- States: IDLE, CHECK, FIRE_ITEM, WAIT_ITEM, FIRE_COIN, WAIT_COIN, REPORT.
- IDLE: req_ready=1. On handshake, latch item/qty/change, go to CHECK.
- CHECK (1 cycle): qty ∉ {1,2} → REPORT BAD_QTY; stock[item] < qty → REPORT NO_STOCK; otherwise FIRE_ITEM. A rejected transaction fires nothing; refund is the upstream block's job.
- FIRE_ITEM: motor_fire[item]=1 for exactly PULSE_CYCLES, then WAIT_ITEM.
- WAIT_ITEM: on mech_done, stock[item] decrements and remaining qty decrements; if qty remains → FIRE_ITEM, else change>0 → FIRE_COIN, else REPORT OK.
- FIRE_COIN: coin10_fire if remaining change ≥2, else coin5_fire (greedy), for PULSE_CYCLES; then WAIT_COIN.
- WAIT_COIN: on mech_done subtract 2 (10-hopper) or 1 (5-hopper); remaining 0 → REPORT OK, else FIRE_COIN.
- Timeout: if a WAIT state lasts TIMEOUT_CYCLES with no mech_done → REPORT FAULT; remaining items and change are abandoned, and stock is decremented only for acknowledged items.
- mech_done is ignored outside WAIT states.
- REPORT: done_valid=1 for one cycle with the status, then IDLE.
- Restock: load_en is honoured in every state. If it coincides with a decrement of the same slot, the load value wins.
- At most one of motor_fire/coin5_fire/coin10_fire is high in any cycle.

## Timing
- Reset: state IDLE; every output 0 except req_ready, which is 1 from the first cycle after reset; all stock counters 0; latched request cleared. A reset mid-transaction drops all fire outputs on the next edge, with no done_valid.
- Handshake at edge N: CHECK during N+1; first motor pulse occupies N+2 … N+1+PULSE_CYCLES.
- mech_done in WAIT cycle M: next FIRE begins at M+1, or REPORT at M+1.
- Minimum OK transaction (qty 1, change 0, mech_done in the first WAIT cycle): done_valid at N+3+PULSE_CYCLES.
- Reject: done_valid at N+2.
- The timeout counter starts at 0 on WAIT entry; the fault is taken on the cycle the count reaches TIMEOUT_CYCLES.

## Structure
- Shared package vend_pkg: the state enum, the status codes (OK/NO_STOCK/BAD_QTY/FAULT), coin unit constants (COIN5=1, COIN10=2 in 5-unit units), and the slot count 4.
- Sub-module vend_act_timer: a single counter that provides the fire-pulse length and the acknowledge timeout. Inputs are start, wait-phase, and ack; outputs are pulse_active and timeout. One instance is shared by all actuators.

## Test plan
- load slot2=5; request item2 qty2 change3, mech_done 3 cycles into each wait → motor_fire=4'b0100 pulsed twice, then coin10 once and coin5 once; done_status OK; stock slot2=3.
- Stock slot0=1; request qty2 → no fire outputs, done_valid at N+2 with NO_STOCK; stock unchanged.
- qty=0 and qty=3 → BAD_QTY at N+2; no actuation.
- item1 stock 4, change 0, mech_done withheld → FAULT exactly PULSE_CYCLES+TIMEOUT_CYCLES+1 cycles after CHECK; stock stays 4.
- load_en to slot3 (count 9) on the same cycle mech_done acks slot3 → stock slot3=9.
- reset asserted during FIRE_COIN → all fire outputs 0 and req_ready 1 on the next cycle; stock all 0; no done_valid.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense sequencer.
package vend_pkg;

    localparam int NUM_SLOTS = 4;

    // Coin values expressed in 5-unit steps.
    localparam logic [2:0] COIN5  = 3'd1;
    localparam logic [2:0] COIN10 = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FIRE_ITEM,
        ST_WAIT_ITEM,
        ST_FIRE_COIN,
        ST_WAIT_COIN,
        ST_REPORT
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OK       = 2'd0,
        STATUS_NO_STOCK = 2'd1,
        STATUS_BAD_QTY  = 2'd2,
        STATUS_FAULT    = 2'd3
    } status_t;

    // Greedy coin choice: use the 10-unit hopper while at least two 5-unit steps remain.
    function automatic logic [2:0] coin_unit(input logic [2:0] change);
        return (change >= COIN10) ? COIN10 : COIN5;
    endfunction

endpackage

// File: rtl/vend_act_timer.sv
// Shared actuator timer: one counter measures the fire pulse, then the acknowledge window.
module vend_act_timer #(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic wait_phase,
    input  logic ack,
    output logic pulse_active,
    output logic timeout
);

    localparam int MAX_COUNT = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count pulse cycles, rearm at the end of the pulse so the wait phase starts from 0.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            count <= '0;
        end else if (wait_phase) begin
            count <= ack ? '0 : count + CNT_W'(1);
        end else if (count >= PULSE_LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // High while the fire pulse continues past the current cycle.
    assign pulse_active = !wait_phase && (count < PULSE_LAST);
    // Last cycle of the acknowledge window with no acknowledge seen.
    assign timeout      = wait_phase && !ack && (count == TIMEOUT_LAST);

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Dispense sequencer: validates a vend request against stock and fires motors, then
// coin hoppers, strictly one at a time, waiting for a mechanism acknowledge after each.
module vend_dispense_sequencer
    import vend_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int STOCK_W        = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_item,
    input  logic [1:0]             req_qty,
    input  logic [2:0]             req_change,
    input  logic                   load_en,
    input  logic [1:0]             load_item,
    input  logic [STOCK_W-1:0]     load_count,
    input  logic                   mech_done,
    output logic [3:0]             motor_fire,
    output logic                   coin5_fire,
    output logic                   coin10_fire,
    output logic                   done_valid,
    output logic [1:0]             done_status,
    output logic [4*STOCK_W-1:0]   stock
);

    state_t           state, next_state;
    status_t          status_q, status_next;
    logic             set_status;
    logic             start;
    logic [1:0]       item_q;
    logic [1:0]       qty_q;
    logic [2:0]       change_q;
    logic             wait_phase, pulse_active, timeout;
    logic             item_ack, coin_ack;
    logic [STOCK_W-1:0] stock_q [NUM_SLOTS];

    assign wait_phase = (state == ST_WAIT_ITEM) || (state == ST_WAIT_COIN);
    assign item_ack   = (state == ST_WAIT_ITEM) && mech_done;
    assign coin_ack   = (state == ST_WAIT_COIN) && mech_done;

    vend_act_timer #(
        .PULSE_CYCLES   (PULSE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .wait_phase   (wait_phase),
        .ack          (mech_done),
        .pulse_active (pulse_active),
        .timeout      (timeout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Latch the accepted request and track what is still owed to the customer.
    always_ff @(posedge clk) begin
        if (reset) begin
            item_q   <= '0;
            qty_q    <= '0;
            change_q <= '0;
            status_q <= STATUS_OK;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                item_q   <= req_item;
                qty_q    <= req_qty;
                change_q <= req_change;
            end
            if (item_ack)   qty_q    <= qty_q - 2'd1;
            if (coin_ack)   change_q <= change_q - coin_unit(change_q);
            if (set_status) status_q <= status_next;
        end
    end

    // Per-slot stock: restock overrides a same-cycle decrement of the same slot.
    // NOTE: the stock array is held in flops and cleared on reset like any other architectural state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (reset) begin
                stock_q[i] <= '0;
            end else if (load_en && load_item == 2'(i)) begin
                stock_q[i] <= load_count;
            end else if (item_ack && item_q == 2'(i)) begin
                stock_q[i] <= stock_q[i] - STOCK_W'(1);
            end
        end
    end

    // Next-state logic, timer start and completion status selection.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state  = state;
        start       = 1'b0;
        set_status  = 1'b0;
        status_next = STATUS_OK;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (qty_q == 2'd0 || qty_q == 2'd3) begin
                    next_state  = ST_REPORT;
                    set_status  = 1'b1;
                    status_next = STATUS_BAD_QTY;
                end else if (stock_q[item_q] < STOCK_W'(qty_q)) begin
                    next_state  = ST_REPORT;
                    set_status  = 1'b1;
                    status_next = STATUS_NO_STOCK;
                end else begin
                    next_state = ST_FIRE_ITEM;
                    start      = 1'b1;
                end
            end
            ST_FIRE_ITEM: begin
                if (!pulse_active) next_state = ST_WAIT_ITEM;
            end
            ST_WAIT_ITEM: begin
                if (mech_done) begin
                    if (qty_q > 2'd1) begin
                        next_state = ST_FIRE_ITEM;
                        start      = 1'b1;
                    end else if (change_q != 3'd0) begin
                        next_state = ST_FIRE_COIN;
                        start      = 1'b1;
                    end else begin
                        next_state  = ST_REPORT;
                        set_status  = 1'b1;
                        status_next = STATUS_OK;
                    end
                end else if (timeout) begin
                    next_state  = ST_REPORT;
                    set_status  = 1'b1;
                    status_next = STATUS_FAULT;
                end
            end
            ST_FIRE_COIN: begin
                if (!pulse_active) next_state = ST_WAIT_COIN;
            end
            ST_WAIT_COIN: begin
                if (mech_done) begin
                    if (change_q == coin_unit(change_q)) begin
                        next_state  = ST_REPORT;
                        set_status  = 1'b1;
                        status_next = STATUS_OK;
                    end else begin
                        next_state = ST_FIRE_COIN;
                        start      = 1'b1;
                    end
                end else if (timeout) begin
                    next_state  = ST_REPORT;
                    set_status  = 1'b1;
                    status_next = STATUS_FAULT;
                end
            end
            ST_REPORT: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Moore outputs: only one actuator can be driven because only one FIRE state is active.
    always_comb begin
        req_ready   = (state == ST_IDLE);
        motor_fire  = '0;
        coin5_fire  = 1'b0;
        coin10_fire = 1'b0;
        done_valid  = (state == ST_REPORT);
        done_status = 2'd0;
        if (state == ST_FIRE_ITEM) motor_fire[item_q] = 1'b1;
        if (state == ST_FIRE_COIN) begin
            if (coin_unit(change_q) == COIN10) coin10_fire = 1'b1;
            else                               coin5_fire  = 1'b1;
        end
        if (state == ST_REPORT) done_status = status_q;
    end

    // Pack the stock counters, slot 0 in the LSBs.
    always_comb begin
        stock = '0;
        for (int i = 0; i < NUM_SLOTS; i++) stock[i*STOCK_W +: STOCK_W] = stock_q[i];
    end

endmodule
